hazard_forward_ctrl: RTL and testbench

Pipeline hazard and forwarding controller for the 5-stage MIPS core. It sits beside the ID/EX boundary, next to the dependence check logic, and tracks in-flight destination registers in a 3-entry scoreboard covering EX, MEM and WB. Each cycle it produces the EX-stage operand forwarding selects, PC/IF-ID enables, bubble insertion, flush signals and a stall-cycle counter. It sequences load-use stalls, taken-branch and jump flushes, and data-memory wait freezes.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/ins_reg_decode.sv | 59 +++++
 rtl/hazard_forward_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS hazard/forwarding control slice.
package mips_pkg;

  localparam int REG_AW_PKG = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [2:0] OP_IMM_PREFIX = 3'b001;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LDSTALL,
    ST_MWAIT
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_PKG-1:0] dest;
    logic                  is_load;
  } sb_entry_t;

endpackage

// File: rtl/ins_reg_decode.sv
// Register-usage decode of the instruction held in ID.
module ins_reg_decode
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0]       ins,
  input  logic              ins_valid,
  output logic              writes,
  output logic [REG_AW-1:0] dest,
  output logic              is_load,
  output logic              uses_rs,
  output logic              uses_rt
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              unused_bits;

  assign opcode      = ins[31:26];
  assign rt          = ins[16 +: REG_AW];
  assign rd          = ins[11 +: REG_AW];
  assign unused_bits = ^{ins[25:21], ins[10:0]};

  // Classify the opcode; a write to r0 is no write at all.
  always_comb begin
    writes  = 1'b0;
    dest    = '0;
    is_load = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    if (ins_valid) begin
      if (opcode == OP_RTYPE) begin
        writes  = 1'b1;
        dest    = rd;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end else if (opcode[5:3] == OP_IMM_PREFIX) begin
        writes  = 1'b1;
        dest    = rt;
        uses_rs = 1'b1;
      end else if (opcode == OP_LW) begin
        writes  = 1'b1;
        dest    = rt;
        is_load = 1'b1;
        uses_rs = 1'b1;
      end else if (opcode == OP_SW || opcode == OP_BEQ || opcode == OP_BNE) begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
    end
    if (dest == '0) begin
      writes  = 1'b0;
      is_load = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: scoreboard of EX/MEM/WB destinations,
// registered EX operand selects, stall/flush sequencing and stall counter.
module hazard_forward_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             ins_valid,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             flush_ifid,
  output logic             idex_bubble,
  output logic             pipe_en,
  output logic [1:0]       mux_sel_A,
  output logic [1:0]       mux_sel_B,
  output logic [CNT_W-1:0] stall_count
);

  logic              dec_writes;
  logic [REG_AW-1:0] dec_dest;
  logic              dec_is_load;
  logic              dec_uses_rs;
  logic              dec_uses_rt;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              use_a;
  logic              use_b;
  logic              is_jump;
  logic              load_use;
  sb_entry_t         sb_ex;
  sb_entry_t         sb_mem;
  sb_entry_t         sb_wb;
  logic              unused_wb;
  state_t            state;
  state_t            ret_state;
  state_t            eff_state;
  state_t            next_state;

  ins_reg_decode #(.REG_AW(REG_AW)) u_decode (
    .ins       (ins),
    .ins_valid (ins_valid),
    .writes    (dec_writes),
    .dest      (dec_dest),
    .is_load   (dec_is_load),
    .uses_rs   (dec_uses_rs),
    .uses_rt   (dec_uses_rt)
  );

  assign rs        = ins[21 +: REG_AW];
  assign rt        = ins[16 +: REG_AW];
  assign use_a     = dec_uses_rs && (rs != '0);
  assign use_b     = dec_uses_rt && (rt != '0);
  assign is_jump   = ins_valid && (ins[31:26] == OP_J);
  assign unused_wb = ^sb_wb;

  assign load_use = sb_ex.valid && sb_ex.is_load &&
                    ((use_a && (rs == sb_ex.dest)) || (use_b && (rt == sb_ex.dest)));

  // While frozen in MWAIT the pipe behaves as the state it was frozen in.
  assign eff_state = (state == ST_MWAIT) ? ret_state : state;

  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] src,
                                         input sb_entry_t ex, input sb_entry_t mem);
    if (!used)                                       return FWD_RF;
    if (ex.valid && ex.dest == src && !ex.is_load)   return FWD_EXMEM;
    if (mem.valid && mem.dest == src)                return FWD_MEMWB;
    return FWD_RF;
  endfunction

  // Next state and pipeline control, highest-priority event first.
  always_comb begin
    next_state  = eff_state;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    pipe_en     = 1'b1;
    flush_ifid  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      pipe_en     = 1'b0;
      flush_ifid  = 1'b1;
      idex_bubble = 1'b1;
      next_state  = ST_RUN;
    end else if (!mem_ready) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      pipe_en    = 1'b0;
      next_state = ST_MWAIT;
    end else if (branch_taken) begin
      flush_ifid  = 1'b1;
      idex_bubble = 1'b1;
      next_state  = ST_RUN;
    end else if (eff_state == ST_RUN && load_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      next_state  = ST_LDSTALL;
    end else begin
      flush_ifid = is_jump;
      next_state = ST_RUN;
    end
  end

  // State register; remember where to resume when a memory wait begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
    end else begin
      state <= next_state;
      if (!mem_ready) ret_state <= eff_state;
    end
  end

  // ---- ID/EX boundary: scoreboard shift and forwarding selects ----
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_ex     <= '0;
      sb_mem    <= '0;
      sb_wb     <= '0;
      mux_sel_A <= FWD_RF;
      mux_sel_B <= FWD_RF;
    end else if (pipe_en) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      if (idex_bubble) begin
        sb_ex     <= '0;
        mux_sel_A <= FWD_RF;
        mux_sel_B <= FWD_RF;
      end else begin
        sb_ex     <= '{valid: dec_writes, dest: dec_dest, is_load: dec_is_load};
        mux_sel_A <= fwd_sel(use_a, rs, sb_ex, sb_mem);
        mux_sel_B <= fwd_sel(use_b, rt, sb_ex, sb_mem);
      end
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!pc_en && !(&stall_count)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed vector table, a reset-in-stall
// sequence, and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins;
  logic        ins_valid, branch_taken, mem_ready;
  logic        pc_en, ifid_en, flush_ifid, idex_bubble, pipe_en;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic [15:0] stall_count;
  logic        s_pc_en, s_ifid_en, s_flush_ifid, s_idex_bubble, s_pipe_en;
  logic [1:0]  s_mux_sel_A, s_mux_sel_B;
  logic [2:0]  s_stall_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .flush_ifid(flush_ifid),
    .idex_bubble(idex_bubble), .pipe_en(pipe_en),
    .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .stall_count(stall_count)
  );

  // Narrow-counter instance to observe saturation within a short run.
  hazard_forward_ctrl #(.REG_AW(5), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .ins(ins), .ins_valid(ins_valid),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .flush_ifid(s_flush_ifid),
    .idex_bubble(s_idex_bubble), .pipe_en(s_pipe_en),
    .mux_sel_A(s_mux_sel_A), .mux_sel_B(s_mux_sel_B), .stall_count(s_stall_count)
  );

  typedef struct {
    logic [31:0] ins;
    logic vld, bt, mr, rst;
    logic pc, ifid, fl, bub, pipe;
    logic [1:0] sa, sb;
    int cnt;
  } vec_t;

  typedef struct {
    int wr; bit ld; int s1; int s2; bit jmp;
  } dinfo_t;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int funct);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic vec_t mk(logic [31:0] i, logic v, logic bt, logic mr, logic rst,
                              logic pc, logic ifid, logic fl, logic bub, logic pipe,
                              logic [1:0] sa, logic [1:0] sb, int cnt);
    vec_t r;
    r.ins = i; r.vld = v; r.bt = bt; r.mr = mr; r.rst = rst;
    r.pc = pc; r.ifid = ifid; r.fl = fl; r.bub = bub; r.pipe = pipe;
    r.sa = sa; r.sb = sb; r.cnt = cnt;
    return r;
  endfunction
  function automatic vec_t nrm(logic [31:0] i, logic v, logic [1:0] sa, logic [1:0] sb, int cnt);
    return mk(i, v, 0, 1, 0, 1, 1, 0, 0, 1, sa, sb, cnt);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, string tag);
    ins = v.ins; ins_valid = v.vld; branch_taken = v.bt; mem_ready = v.mr; reset = v.rst;
    @(negedge clk);
    n_vec++;
    chk({tag, ".pc_en"},       32'(pc_en),       32'(v.pc));
    chk({tag, ".ifid_en"},     32'(ifid_en),     32'(v.ifid));
    chk({tag, ".flush_ifid"},  32'(flush_ifid),  32'(v.fl));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(v.bub));
    chk({tag, ".pipe_en"},     32'(pipe_en),     32'(v.pipe));
    chk({tag, ".mux_sel_A"},   32'(mux_sel_A),   32'(v.sa));
    chk({tag, ".mux_sel_B"},   32'(mux_sel_B),   32'(v.sb));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(v.cnt));
    chk({tag, ".stall_count_sat3"}, 32'(s_stall_count), 32'((v.cnt > 7) ? 7 : v.cnt));
    @(posedge clk); #1;
  endtask

  // ---------------- behavioural model ----------------
  int m_ex_wr, m_mem_wr;
  bit m_ex_ld, m_ldstall;
  logic [1:0] m_sa, m_sb;
  int m_cnt;

  task automatic m_reset();
    m_ex_wr = -1; m_mem_wr = -1; m_ex_ld = 0; m_ldstall = 0;
    m_sa = 0; m_sb = 0; m_cnt = 0;
  endtask

  function automatic dinfo_t m_dec(logic [31:0] i, logic v);
    dinfo_t d;
    int op, rs, rt, rd;
    op = int'(i[31:26]); rs = int'(i[25:21]); rt = int'(i[20:16]); rd = int'(i[15:11]);
    d.wr = -1; d.ld = 0; d.s1 = -1; d.s2 = -1; d.jmp = 0;
    if (v) begin
      if (op == 0)                          begin d.wr = rd; d.s1 = rs; d.s2 = rt; end
      else if ((op >> 3) == 1)              begin d.wr = rt; d.s1 = rs; end
      else if (op == 35)                    begin d.wr = rt; d.ld = 1; d.s1 = rs; end
      else if (op == 43 || op == 4 || op == 5) begin d.s1 = rs; d.s2 = rt; end
      else if (op == 2)                     d.jmp = 1;
    end
    if (d.wr == 0) begin d.wr = -1; d.ld = 0; end
    if (d.s1 == 0) d.s1 = -1;
    if (d.s2 == 0) d.s2 = -1;
    return d;
  endfunction

  function automatic logic [1:0] m_fwd(int s);
    if (s < 0) return 2'd0;
    if (m_ex_wr == s && !m_ex_ld) return 2'd1;
    if (m_mem_wr == s) return 2'd2;
    return 2'd0;
  endfunction

  task automatic m_eval(input logic [31:0] i, input logic v, bt, mr, rst,
                        output vec_t e, output bit lu_taken);
    dinfo_t d;
    bit lu;
    d  = m_dec(i, v);
    lu = !m_ldstall && m_ex_ld && m_ex_wr >= 0 && (m_ex_wr == d.s1 || m_ex_wr == d.s2);
    e = mk(i, v, bt, mr, rst, 1, 1, 0, 0, 1, m_sa, m_sb, m_cnt);
    lu_taken = 0;
    if (rst)           begin e.pc = 0; e.ifid = 0; e.pipe = 0; e.fl = 1; e.bub = 1; end
    else if (!mr)      begin e.pc = 0; e.ifid = 0; e.pipe = 0; end
    else if (bt)       begin e.fl = 1; e.bub = 1; end
    else if (lu)       begin e.pc = 0; e.ifid = 0; e.bub = 1; lu_taken = 1; end
    else if (d.jmp)    e.fl = 1;
  endtask

  task automatic m_update(vec_t in);
    vec_t e;
    bit lut;
    dinfo_t d;
    m_eval(in.ins, in.vld, in.bt, in.mr, in.rst, e, lut);
    d = m_dec(in.ins, in.vld);
    if (in.rst) begin
      m_reset();
    end else begin
      if (!e.pc && m_cnt < 65535) m_cnt++;
      if (e.pipe) begin
        m_sa = e.bub ? 2'd0 : m_fwd(d.s1);
        m_sb = e.bub ? 2'd0 : m_fwd(d.s2);
        m_mem_wr = m_ex_wr;
        m_ex_wr  = e.bub ? -1 : d.wr;
        m_ex_ld  = e.bub ? 1'b0 : d.ld;
        m_ldstall = lut;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    logic [31:0] ADD3, SUB4, LW3, ADD4, OR6, LW5, ADD6, LW7, ADD8, JMP, LW9, ADDI10, SW10, NOP;
    vec_t v, e;
    bit lut;

    ADD3   = enc_r(1, 2, 3, 32);
    SUB4   = enc_r(3, 5, 4, 34);
    LW3    = enc_i(6'b100011, 1, 3, 0);
    ADD4   = enc_r(3, 3, 4, 32);
    OR6    = enc_r(3, 0, 6, 37);
    LW5    = enc_i(6'b100011, 1, 5, 0);
    ADD6   = enc_r(5, 1, 6, 32);
    LW7    = enc_i(6'b100011, 2, 7, 0);
    ADD8   = enc_r(7, 1, 8, 32);
    JMP    = {6'b000010, 26'd16};
    LW9    = enc_i(6'b100011, 2, 9, 0);
    ADDI10 = enc_i(6'b001000, 1, 10, 5);
    SW10   = enc_i(6'b101011, 10, 10, 0);
    NOP    = 32'd0;

    tbl.push_back(mk(NOP, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0));   // reset state
    tbl.push_back(nrm(ADD3, 1, 0, 0, 0));
    tbl.push_back(nrm(SUB4, 1, 0, 0, 0));
    tbl.push_back(nrm(NOP,  0, 1, 0, 0));                          // SUB gets EX/MEM on A
    tbl.push_back(nrm(LW3,  1, 0, 0, 0));
    tbl.push_back(mk(ADD4, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));  // load-use
    tbl.push_back(nrm(ADD4, 1, 0, 0, 1));                          // stall cycle done
    tbl.push_back(nrm(NOP,  0, 2, 2, 1));                          // ADD gets MEM/WB both
    tbl.push_back(nrm(ADD3, 1, 0, 0, 1));
    tbl.push_back(nrm(NOP,  0, 0, 0, 1));
    tbl.push_back(nrm(OR6,  1, 0, 0, 1));
    tbl.push_back(nrm(NOP,  0, 2, 0, 1));                          // r0 never forwarded
    tbl.push_back(nrm(LW5,  1, 0, 0, 1));
    tbl.push_back(mk(ADD6, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 1));  // branch beats load-use
    tbl.push_back(nrm(NOP,  0, 0, 0, 1));
    tbl.push_back(nrm(LW7,  1, 0, 0, 1));
    tbl.push_back(nrm(NOP,  0, 0, 0, 1));
    tbl.push_back(mk(ADD8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));  // memory wait x3
    tbl.push_back(mk(ADD8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(ADD8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(nrm(ADD8, 1, 0, 0, 4));
    tbl.push_back(nrm(NOP,  0, 2, 0, 4));                          // LW still in MEM
    tbl.push_back(mk(JMP,  1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 4));
    tbl.push_back(nrm(LW9,  1, 0, 0, 4));
    tbl.push_back(mk(JMP,  1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 4));  // J ignores load in EX
    tbl.push_back(nrm(ADDI10, 1, 0, 0, 4));
    tbl.push_back(nrm(SW10, 1, 0, 0, 4));
    tbl.push_back(nrm(NOP,  0, 1, 1, 4));
    tbl.push_back(nrm(NOP,  0, 0, 0, 4));

    ins = 0; ins_valid = 0; branch_taken = 0; mem_ready = 1; reset = 1;
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[k]) apply(tbl[k], $sformatf("tbl%0d", k));

    // Reset arriving during the load-use stall cycle.
    apply(nrm(LW3, 1, 0, 0, 4), "rst_ld.h1");
    apply(mk(ADD4, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 4), "rst_ld.h2");
    apply(mk(ADD4, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 5), "rst_ld.h3");
    apply(nrm(ADD4, 1, 0, 0, 0), "rst_ld.h4");
    apply(nrm(NOP,  0, 0, 0, 0), "rst_ld.h5");

    // Randomized traffic against the model.
    reset = 1; ins_valid = 0; branch_taken = 0; mem_ready = 1;
    @(posedge clk); #1;
    m_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 8))
        0:       op = 6'b000000;
        1:       op = {3'b001, 3'($urandom_range(0, 7))};
        2, 8:    op = 6'b100011;
        3:       op = 6'b101011;
        4:       op = 6'b000100;
        5:       op = 6'b000101;
        6:       op = 6'b000010;
        default: op = 6'b111000;
      endcase
      v.ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 11'($urandom)};
      v.vld = ($urandom_range(0, 9) != 0);
      v.bt  = ($urandom_range(0, 9) == 0);
      v.mr  = ($urandom_range(0, 4) != 0);
      v.rst = ($urandom_range(0, 99) == 0);
      m_eval(v.ins, v.vld, v.bt, v.mr, v.rst, e, lut);
      apply(e, $sformatf("rnd%0d", n));
      m_update(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
